// File: rtl/carbon_arb_pkg.sv
// carbon_arb_pkg
//   Shared types and helpers for the carbon weighted round-robin arbiter.
//   arb_state_t    : arbiter ownership state
//   ARB_MAX_M      : largest supported number of masters
//   onehot_to_idx  : binary index of the set bit in a one-hot vector
package carbon_arb_pkg;

  localparam int ARB_MAX_M = 8;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  function automatic int onehot_to_idx(input logic [ARB_MAX_M-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < ARB_MAX_M; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/carbon_rr_pick.sv
// carbon_rr_pick
//   Combinational rotating-priority picker. Returns the first unmasked
//   requester found searching upward from i_ptr, wrapping modulo M.
//   i_req   : per-master request
//   i_mask  : masters excluded from this search
//   i_ptr   : index where the search starts
//   o_found : at least one eligible requester
//   o_idx   : index of the winner (0 when none found)
module carbon_rr_pick #(
  parameter int M     = 4,
  parameter int IDX_W = 2
) (
  input  logic [M-1:0]     i_req,
  input  logic [M-1:0]     i_mask,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  logic [M-1:0] w_cand;
  int           w_pos;

  always_comb begin
    w_cand  = i_req & ~i_mask;
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    for (int k = 0; k < M; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= M) w_pos = w_pos - M;
      if (!o_found && w_cand[w_pos[IDX_W-1:0]]) begin
        o_found = 1'b1;
        o_idx   = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/carbon_wrr_arbiter.sv
// carbon_wrr_arbiter
//   Weighted round-robin ownership arbiter for a shared fabric slave.
//   The owner keeps the resource for weight+1 completed transactions per
//   turn; a lock bit from the owner pins ownership across completions.
//   i_clk         : system clock
//   i_rst_n       : synchronous active-low reset
//   i_req         : per-master request, held until its transaction completes
//   i_lock        : per-master lock, honoured only for the current owner
//   i_weight      : packed per-master weights, master i at [i*WEIGHT_W +: WEIGHT_W]
//   i_xact_done   : one-cycle pulse, owner's transaction completed
//   o_grant       : one-hot owner
//   o_grant_valid : an owner exists
//   o_grant_idx   : binary owner index, 0 when idle
//   o_credit      : transactions remaining in the owner's turn
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | no owner; any request is granted on the next edge
// ARB_OWNED | r_idx owns the slave; completions consume r_credit
module carbon_wrr_arbiter
  import carbon_arb_pkg::*;
#(
  parameter int M        = 4,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(M)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [M-1:0]          i_req,
  input  logic [M-1:0]          i_lock,
  input  logic [M*WEIGHT_W-1:0] i_weight,
  input  logic                  i_xact_done,
  output logic [M-1:0]          o_grant,
  output logic                  o_grant_valid,
  output logic [IDX_W-1:0]      o_grant_idx,
  output logic [WEIGHT_W:0]     o_credit
);

  arb_state_t          r_state;
  logic [M-1:0]        r_grant;
  logic                r_valid;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_ptr;
  logic [WEIGHT_W:0]   r_credit;

  logic [IDX_W-1:0]    w_ptr_next;
  logic [IDX_W-1:0]    w_pick_ptr;
  logic [M-1:0]        w_mask;
  logic                w_found;
  logic [IDX_W-1:0]    w_pick_idx;
  logic [M-1:0]        w_pick_oh;
  logic [WEIGHT_W:0]   w_load;
  logic [WEIGHT_W:0]   w_credit_dec;
  logic                w_keep;
  logic                w_consume;

  always_comb begin
    w_ptr_next   = (r_idx == IDX_W'(M-1)) ? '0 : r_idx + 1'b1;
    w_pick_ptr   = (r_state == ARB_OWNED) ? w_ptr_next : r_ptr;
    // On handover the outgoing owner is masked out unless nobody else asks,
    // so a lone requester is re-granted back-to-back.
    w_mask       = ((r_state == ARB_OWNED) && ((i_req & ~r_grant) != '0)) ? r_grant : '0;
    w_pick_oh    = {{(M-1){1'b0}}, 1'b1} << w_pick_idx;
    w_load       = {1'b0, i_weight[int'(w_pick_idx)*WEIGHT_W +: WEIGHT_W]} + (WEIGHT_W+1)'(1);
    w_credit_dec = r_credit - (WEIGHT_W+1)'(1);
    w_keep       = (w_credit_dec != '0) && i_req[r_idx];
    w_consume    = i_xact_done && !i_lock[r_idx];
  end

  carbon_rr_pick #(
    .M     (M),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (i_req),
    .i_mask  (w_mask),
    .i_ptr   (w_pick_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ARB_IDLE;
      r_grant  <= '0;
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_ptr    <= '0;
      r_credit <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_state  <= ARB_OWNED;
            r_grant  <= w_pick_oh;
            r_valid  <= 1'b1;
            r_idx    <= w_pick_idx;
            r_credit <= w_load;
          end
        end
        ARB_OWNED: begin
          if (w_consume) begin
            if (w_keep) begin
              r_credit <= w_credit_dec;
            end else begin
              r_ptr <= w_ptr_next;
              if (w_found) begin
                r_grant  <= w_pick_oh;
                r_idx    <= w_pick_idx;
                r_credit <= w_load;
              end else begin
                r_state  <= ARB_IDLE;
                r_grant  <= '0;
                r_valid  <= 1'b0;
                r_idx    <= '0;
                r_credit <= '0;
              end
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_valid;
  assign o_grant_idx   = r_idx;
  assign o_credit      = r_credit;

`ifndef SYNTHESIS
  a_req_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_state == ARB_OWNED && !i_xact_done) |-> i_req[r_idx])
    else $error("owner %0d dropped req before xact_done", r_idx);

  a_done_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_state == ARB_IDLE) |-> !i_xact_done)
    else $error("xact_done pulsed with no owner");

  a_grant_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(r_grant) && (r_valid == (r_grant != '0)))
    else $error("grant not one-hot or valid inconsistent: %b", r_grant);

  a_idx_match: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_valid |-> (onehot_to_idx(ARB_MAX_M'(r_grant)) == int'(r_idx)))
    else $error("grant_idx %0d does not match grant %b", r_idx, r_grant);
`endif

endmodule

// File: tb/tb_carbon_wrr_arbiter.sv
module tb_carbon_wrr_arbiter;

  localparam int M  = 4;
  localparam int WW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [M-1:0]    req = '0;
  logic [M-1:0]    lock = '0;
  logic [M*WW-1:0] weight = '0;
  logic            done = 1'b0;
  logic [M-1:0]    grant;
  logic            grant_valid;
  logic [IW-1:0]   grant_idx;
  logic [WW:0]     credit;

  int tests = 0;
  int fails = 0;

  // reference: owner index (-1 = none), rotate pointer, remaining credit
  int m_owner  = -1;
  int m_ptr    = 0;
  int m_credit = 0;

  carbon_wrr_arbiter #(.M(M), .WEIGHT_W(WW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req         (req),
    .i_lock        (lock),
    .i_weight      (weight),
    .i_xact_done   (done),
    .o_grant       (grant),
    .o_grant_valid (grant_valid),
    .o_grant_idx   (grant_idx),
    .o_credit      (credit)
  );

  always #5 clk = ~clk;

  function automatic logic bit_of(input logic [M-1:0] v, input int i);
    return v[i[IW-1:0]];
  endfunction

  function automatic int wt(input int i);
    return int'(weight[i*WW +: WW]);
  endfunction

  function automatic int first_req(input logic [M-1:0] r, input int from);
    for (int k = 0; k < M; k++) begin
      if (bit_of(r, (from + k) % M)) return (from + k) % M;
    end
    return -1;
  endfunction

  task automatic model_update();
    int w;
    logic [M-1:0] others;
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_credit = 0;
    end else if (m_owner < 0) begin
      w = first_req(req, m_ptr);
      if (w >= 0) begin m_owner = w; m_credit = wt(w) + 1; end
    end else if (done && !bit_of(lock, m_owner)) begin
      m_credit = m_credit - 1;
      if (!(m_credit > 0 && bit_of(req, m_owner))) begin
        m_ptr  = (m_owner + 1) % M;
        others = req & ~(M'(1) << m_owner);
        w = first_req(others, m_ptr);
        if (w < 0) w = first_req(req, m_ptr);
        if (w >= 0) begin m_owner = w; m_credit = wt(w) + 1; end
        else begin m_owner = -1; m_credit = 0; end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    check("grant",  32'(grant),       (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check("valid",  32'(grant_valid), (m_owner < 0) ? 32'd0 : 32'd1);
    check("idx",    32'(grant_idx),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("credit", 32'(credit),      32'(m_credit));
  endtask

  task automatic cyc(input logic [M-1:0] r, input logic [M-1:0] l, input logic d);
    req = r; lock = l; done = d;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; done = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [M-1:0] r, l;
    logic d;

    // reset and simple alternation with zero weights
    req = '0; lock = '0; weight = '0;
    do_reset();
    check("reset_grant", 32'(grant), 32'd0);
    cyc(4'b0101, '0, 1'b0);
    check("s1_first", 32'(grant), 32'b0001);
    cyc(4'b0101, '0, 1'b1);
    check("s1_second", 32'(grant), 32'b0100);
    cyc(4'b0101, '0, 1'b1);
    check("s1_wrap", 32'(grant), 32'b0001);

    // weight[0]=2: master 0 gets three completions per turn
    do_reset();
    weight = 16'h0002;
    cyc(4'b0011, '0, 1'b0);
    check("s2_credit3", 32'(credit), 32'd3);
    cyc(4'b0011, '0, 1'b1);
    check("s2_credit2", 32'(credit), 32'd2);
    cyc(4'b0011, '0, 1'b1);
    check("s2_credit1", 32'(credit), 32'd1);
    cyc(4'b0011, '0, 1'b1);
    check("s2_to_m1", 32'(grant), 32'b0010);
    cyc(4'b0011, '0, 1'b1);
    check("s2_back_m0", 32'(grant), 32'b0001);
    check("s2_reload", 32'(credit), 32'd3);

    // lock pins ownership regardless of completions
    do_reset();
    weight = '0;
    cyc(4'b0010, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 4'b0010, 1'b1);
      check("s3_locked", 32'(grant), 32'b0010);
    end
    cyc(4'b1111, '0, 1'b1);
    check("s3_unlock", 32'(grant), 32'b0100);

    // sole requester re-granted back-to-back
    do_reset();
    weight = 16'h0100;
    cyc(4'b0100, '0, 1'b0);
    cyc(4'b0100, '0, 1'b1);
    check("s4_credit1", 32'(credit), 32'd1);
    cyc(4'b0100, '0, 1'b1);
    check("s4_regrant", 32'(grant), 32'b0100);
    check("s4_valid", 32'(grant_valid), 32'd1);
    check("s4_reload", 32'(credit), 32'd2);

    // all requests drop on the final completion
    cyc(4'b0100, '0, 1'b1);
    cyc(4'b0000, '0, 1'b1);
    check("s5_idle", 32'(grant_valid), 32'd0);
    cyc(4'b0000, '0, 1'b0);
    cyc(4'b0000, '0, 1'b0);
    weight = 16'h1100;
    cyc(4'b1000, '0, 1'b0);
    check("s5_m3", 32'(grant), 32'b1000);

    // reset mid-turn
    cyc(4'b1000, '0, 1'b0);
    check("s6_credit2", 32'(credit), 32'd2);
    req = 4'b1001;
    do_reset();
    check("s6_reset", 32'(grant), 32'd0);
    cyc(4'b1001, '0, 1'b0);
    check("s6_m0_first", 32'(grant), 32'b0001);

    // randomized traffic obeying the request/done protocol
    for (int n = 0; n < 3000; n++) begin
      r = M'($urandom & $urandom);
      if ($urandom_range(0, 99) < 5) weight = (M*WW)'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        req = r;
        do_reset();
      end else begin
        d = (m_owner >= 0) && ($urandom_range(0, 2) == 0);
        l = ($urandom_range(0, 3) == 0) ? M'($urandom) : '0;
        if (m_owner >= 0 && !(d && !bit_of(l, m_owner)))
          r = r | (M'(1) << m_owner);
        cyc(r, l, d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/carbon_wrr_arbiter.md
# carbon_wrr_arbiter

Weighted round-robin arbiter that shares a single fabric slave resource (e.g. the system RAM or MMIO port) among up to M requesting masters (CPU memory, CPU I/O, FPU, DMA). It grants one master at a time, keeps that master as owner for a programmable number of completed transactions, and supports a lock that pins ownership across multi-transaction sequences. It sits between the master request signals and the fabric mux select, providing the ownership decision only; it never touches data.

## Interface
- M, 4, number of requesting masters (2..8)
- WEIGHT_W, 4, width of each per-master weight field
- IDX_W, $clog2(M), width of grant index
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- req  in  M  per-master request; must stay high until that master's transaction completes
- lock  in  M  per-master lock; while owner's bit is high, completions do not consume credit or release ownership
- weight  in  M*WEIGHT_W  packed weights, master i at [i*WEIGHT_W +: WEIGHT_W]; owner receives weight+1 transactions per turn
- xact_done  in  1  one-cycle pulse: owner's current transaction completed (response accepted)
- grant  out  M  one-hot owner, registered
- grant_valid  out  1  high when grant is nonzero
- grant_idx  out  IDX_W  binary index of owner; 0 when idle
- credit  out  WEIGHT_W+1  transactions remaining in owner's turn (debug/visibility)

## Operation
- States: IDLE, OWNED.
- Reset: grant=0, grant_valid=0, grant_idx=0, credit=0, rotate pointer ptr=0, state IDLE.
- IDLE: if any req, select winner = first requester searching from ptr upward, wrapping modulo M; next cycle grant=onehot(winner), grant_idx=winner, credit=weight[winner]+1 (sampled at grant time), state OWNED. No req: stay IDLE.
- OWNED, xact_done with lock[owner]=1: no change.
- OWNED, xact_done with lock[owner]=0: credit decrements. If decremented credit>0 and req[owner]=1: keep owner. Otherwise set ptr=owner+1 (mod M) and re-arbitrate in the same cycle from that ptr over current req with the owner bit masked (the owner is reconsidered only if it is the sole requester): winner found -> grant switches next cycle with no bubble, credit reloads; none -> IDLE, grant=0.
- OWNED, no xact_done: grant is held regardless of req (dropping req without done is a protocol violation; assertion fires, grant held).
- Weight changes take effect only at the next grant load; credit never reloads mid-turn.
- Unused weight bits of masters >= M do not exist; weight=0 means exactly 1 transaction per turn.
- xact_done in IDLE is ignored (assertion).

## Timing
- Request-to-grant latency: 1 cycle from IDLE (req sampled in cycle N, grant visible N+1).
- Handover: xact_done in cycle N -> new grant visible N+1; owner deasserted the same edge. Zero idle cycles between owners while requests are pending.
- All outputs registered; no combinational path from req/xact_done to grant.
- Worst-case wait for master i with lock never asserted: sum over j != i of (weight[j]+1) completed transactions.
- Synchronous reset mid-turn: outputs return to reset values on the next edge; in-flight transaction is abandoned (fabric is reset by the same rst_n).

## Structure
- carbon_arb_pkg: arb_state_t enum (ARB_IDLE, ARB_OWNED), function for one-hot-to-index, ARB_MAX_M=8 constant.
- Sub-module carbon_rr_pick: combinational rotating priority picker (inputs req, mask, ptr; outputs found, idx); used for both IDLE and handover selection.
- Top holds state, owner, ptr, credit registers; concurrent assertions (req drop, done while idle, grant one-hot) under synthesis translate_off.

## Test plan
- Reset then req=4'b0101, weights 0: grant=0001 at cycle 1; after done -> 0100; after done -> 0001 (ptr wraps).
- weight[0]=2, req=4'b0011 held: master 0 owns for 3 dones, then master 1 owns 1, then master 0 owns 3 again; credit counts 3,2,1.
- lock[1]=1 with owner 1, 5 dones pulsed, req=4'b1111: grant stays 0010, credit unchanged; lock drops -> next done hands to 0100.
- Owner sole requester with credit exhausted: master 2 re-granted back-to-back, credit reloads to weight[2]+1, grant_valid never drops.
- All reqs drop on final done: grant=0, grant_valid=0 next cycle; new req=1000 two cycles later -> grant=1000 one cycle after.
- rst_n low for one cycle mid-turn (owner 3, credit 2): next cycle all outputs 0, ptr=0; req=4'b1001 -> master 0 granted first.
